led_fade_pwm: RTL and testbench
===============================

# led_fade_pwm

Downstream stage of the rotating LED pattern generator. Consumes its 16-bit `led` pattern and drives the board LED pins through per-channel PWM. Each channel holds a brightness level that jumps to full while its pattern bit is set and decays step by step once the bit clears, so the rotating light leaves a fading trail.

## Interface

- `N`, default 16: number of LED channels.
- `PWM_BITS`, default 4: brightness level width; `MAX = 2**PWM_BITS - 1`.
- `DECAY_DIV`, default 1024: clock cycles per decay step; legal range ≥ 2.
- `clk` input, 1: single system clock; all state updates on its rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `led_in` input, N: pattern from the upstream generator; level-sensitive, sampled every cycle.
- `led_out` output, N: PWM-modulated LED drive, registered, active-high.

## Operation

- **Per-channel state:** `level[i]`, PWM_BITS wide, one per channel.
- **Shared PWM counter `pwm_cnt`:**
  - PWM_BITS wide; counts 0..MAX-1, then wraps to 0.
  - PWM period is MAX cycles (15 at default).
- **Shared decay prescaler `decay_cnt`:**
  - Counts 0..DECAY_DIV-1, then wraps.
  - `decay_tick` is asserted in the cycle where `decay_cnt == DECAY_DIV-1`.
- **Level update, per channel, per cycle, in priority order:**
  - `led_in[i] == 1`: `level[i] <= MAX`. Load beats decay, even on a tick.
  - Else `decay_tick && level[i] != 0`: `level[i] <= level[i] - 1`.
  - Else: hold.
- **Saturation:** level never underflows below 0 and never exceeds MAX.
- **Compare:**
  - `led_out[i] <= (eff[i] > pwm_cnt)`, with `eff[i] = level[i]` when gamma is off.
  - Duty cycle is `eff/MAX`: level MAX is constant on, level 0 is constant off.
- **Independence:** channels are independent; any number of `led_in` bits may be set at once.
- **Trail length:** a full-to-dark decay takes `MAX * DECAY_DIV` cycles after the bit drops (15 × 1024 = 15360 at default).

## Timing

- **Reset values:** `level` all 0, `pwm_cnt` 0, `decay_cnt` 0, `led_out` 0.
- **Reset mid-operation:**
  - All state returns to the reset values on the next edge.
  - `led_in` is ignored in the reset cycle.
- **Latency:**
  - `led_in[i]` high at edge k gives `level[i] = MAX` after edge k.
  - `led_out[i]` = 1 after edge k+1, i.e. 2 edges from input to pin.
- **Decay timing:** with `decay_cnt` free-running from reset, the first `decay_tick` is in cycle DECAY_DIV-1 after reset release, then every DECAY_DIV cycles.
- **Bit drop before a tick:** if a bit drops at edge k, the first decrement happens at the first tick after edge k. Maximum wait is DECAY_DIV cycles.
- **Counter phase:** `pwm_cnt` and `decay_cnt` free-run and are not re-phased by `led_in` activity.

## Configuration

- **`LED_FADE_GAMMA_EN` defined:**
  - `eff[i] = (level[i]*level[i] + MAX) >> PWM_BITS`, computed combinationally.
  - At default width: 0→0, 1→1, 4→1, 8→4, 12→9, 15→15. Endpoints are preserved.
- **Undefined:** `eff[i] = level[i]` (linear).
- **Unaffected either way:** level update, counters and latency are identical.

## Structure

- **Shared package `led_pkg`:**
  - Parameter defaults `LED_N`, `LED_PWM_BITS`, `LED_DECAY_DIV`.
  - Derived constant `LED_PWM_MAX`.
  - Function `led_gamma(level)`.
- **Sub-module `led_fade_ch`:**
  - One channel: level register, load/decay logic, gamma, compare, output flop.
  - Inputs: `clk`, `rst`, `led_in`, `decay_tick`, `pwm_cnt`.
  - Instantiated N times in a generate loop.
- **Top level:** holds `pwm_cnt` and `decay_cnt` only.

## Test plan

Bench overrides `DECAY_DIV=4`; `PWM_BITS=4` unless stated.

1. **Reset:** hold `rst` 3 cycles with `led_in=16'hFFFF` → `led_out=0`, all levels 0 during and 1 cycle after release.
2. **Full on:** `led_in=16'h0001` steady → from the 2nd edge on, `led_out[0]=1` every cycle over 3 PWM periods; `led_out[15:1]=0`.
3. **Decay:** set `led_in[3]` for 10 cycles, then clear → `level[3]` steps 15→14→…→0, one step per 4 cycles. Over each 15-cycle window, high count of `led_out[3]` equals the current level (linear build). Reaches 0 within 60 cycles.
4. **Load vs. tick:** assert `led_in[5]` exactly in a `decay_tick` cycle while `level[5]=7` → `level[5]=15` next edge, not 6.
5. **Gamma on (`LED_FADE_GAMMA_EN`):** hold `level=8` (force) → `led_out` high 4 of every 15 cycles; `level=15` → 15 of 15.
6. **Rotating input / mid-op reset:** drive `led_in` rotating `0x0001`, one position per 6 cycles → levels behind the head are non-increasing with distance. Pulse `rst` 1 cycle mid-run → all levels and `led_out` 0 next edge.

Source files
------------

// File: rtl/led_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_pkg: shared defaults and brightness helper for the LED fade stage.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package led_pkg;

    localparam int LED_N         = 16;
    localparam int LED_PWM_BITS  = 4;
    localparam int LED_DECAY_DIV = 1024;
    localparam int LED_PWM_MAX   = (1 << LED_PWM_BITS) - 1;

    // Squared brightness with a +MAX bias so that levels 0 and MAX map to themselves.
    function automatic int unsigned led_gamma(input int unsigned level, input int unsigned bits);
        return (level * level + ((32'd1 << bits) - 32'd1)) >> bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_fade_ch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_fade_ch: one LED channel (level register, load/decay, PWM compare).    |
// | Optional squared brightness curve when LED_FADE_GAMMA_EN is defined.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module led_fade_ch
    import led_pkg::*;
#(
    parameter int PWM_BITS = LED_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                led_in,
    input  logic                decay_tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led_out
);

    localparam logic [PWM_BITS-1:0] c_level_max = '1;

    logic [PWM_BITS-1:0] level_q;
    logic [PWM_BITS-1:0] level_d;
    logic [PWM_BITS-1:0] eff;
    logic                led_out_q;
    logic                led_out_d;

`ifdef LED_FADE_GAMMA_EN
    assign eff = PWM_BITS'(led_gamma(32'(level_q), PWM_BITS));
`else
    assign eff = level_q;
`endif

    // A set pattern bit reloads full brightness even in a decay-tick cycle.
    always_comb begin
        level_d = level_q;
        if (led_in) begin
            level_d = c_level_max;
        end else if (decay_tick && (level_q != '0)) begin
            level_d = level_q - 1'b1;
        end
    end

    assign led_out_d = (eff > pwm_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q   <= '0;
            led_out_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            led_out_q <= led_out_d;
        end
    end

    assign led_out = led_out_q;

endmodule
`default_nettype wire

// File: rtl/led_fade_pwm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_fade_pwm: per-channel PWM fade of the rotating LED pattern.            |
// | Build option LED_FADE_GAMMA_EN selects a squared brightness curve.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module led_fade_pwm
    import led_pkg::*;
#(
    parameter int N         = LED_N,
    parameter int PWM_BITS  = LED_PWM_BITS,
    parameter int DECAY_DIV = LED_DECAY_DIV
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] led_in,
    output logic [N-1:0] led_out
);

    localparam int DECAY_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    // PWM counter stops at MAX-1 so a level of MAX is on for the whole period.
    localparam logic [PWM_BITS-1:0] c_pwm_last   = PWM_BITS'((2 ** PWM_BITS) - 2);
    localparam logic [DECAY_W-1:0]  c_decay_last = DECAY_W'(DECAY_DIV - 1);

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_d;
    logic [DECAY_W-1:0]  decay_cnt_q;
    logic [DECAY_W-1:0]  decay_cnt_d;
    logic                decay_tick;

    assign decay_tick = (decay_cnt_q == c_decay_last);

    always_comb begin
        pwm_cnt_d   = (pwm_cnt_q == c_pwm_last) ? '0 : pwm_cnt_q + 1'b1;
        decay_cnt_d = decay_tick ? '0 : decay_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q   <= '0;
            decay_cnt_q <= '0;
        end else begin
            pwm_cnt_q   <= pwm_cnt_d;
            decay_cnt_q <= decay_cnt_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        led_fade_ch #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .led_in     (led_in[i]),
            .decay_tick (decay_tick),
            .pwm_cnt    (pwm_cnt_q),
            .led_out    (led_out[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_led_fade_pwm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_led_fade_pwm: directed self-checking bench for led_fade_pwm.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_led_fade_pwm;
    import led_pkg::*;

    localparam int N  = 16;
    localparam int PB = 4;
    localparam int DD = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] led_in;
    logic [N-1:0] led_out;
    logic [PB-1:0] lvl [N];

    int n_checks = 0;
    int n_errors = 0;
    int c        = 0;   // edges since the most recent reset release

    always #5 clk = ~clk;

    led_fade_pwm #(
        .N         (N),
        .PWM_BITS  (PB),
        .DECAY_DIV (DD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .led_in  (led_in),
        .led_out (led_out)
    );

    for (genvar g = 0; g < N; g++) begin : g_mon
        assign lvl[g] = dut.g_ch[g].u_ch.level_q;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (c=%0d)", tag, obs, exp, c);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        c++;
    endtask

    function automatic int exp_eff(input int l);
`ifdef LED_FADE_GAMMA_EN
        return (l * l + 15) >> 4;
`else
        return l;
`endif
    endfunction

    // Channel 3 is loaded through edge 58; ticks land on edges where c%4==0.
    function automatic int lvl3_model(input int cc);
        int v;
        if (cc <= 58) return 15;
        v = 15 - (cc - 56) / 4;
        return (v < 0) ? 0 : v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic any_lvl;
        int   head;

        check("gamma_0",  led_gamma(0, 4), 0);
        check("gamma_1",  led_gamma(1, 4), 1);
        check("gamma_4",  led_gamma(4, 4), 1);
        check("gamma_8",  led_gamma(8, 4), 4);
        check("gamma_12", led_gamma(12, 4), 9);
        check("gamma_15", led_gamma(15, 4), 15);

        // Reset held with all inputs high
        rst    = 1'b1;
        led_in = '1;
        repeat (3) begin
            step();
            check("rst_out",   led_out, 0);
            check("rst_lvl0",  lvl[0], 0);
            check("rst_lvl15", lvl[15], 0);
        end
        rst    = 1'b0;
        led_in = '0;
        c      = 0;
        step();
        check("rel_out",   led_out, 0);
        check("rel_lvl0",  lvl[0], 0);
        check("rel_pwm",   dut.pwm_cnt_q, 1);
        check("rel_decay", dut.decay_cnt_q, 1);

        // Full on: two edges from input to pin
        led_in = 16'h0001;
        step();
        check("on_lvl0",  lvl[0], 15);
        check("on_out_1", led_out, 0);
        step();
        check("on_out_2", led_out, 16'h0001);
        for (int i = 0; i < 45; i++) begin
            step();
            check("full_on", led_out, 16'h0001);
        end
        check("pwm_phase",   dut.pwm_cnt_q, 48 % 15);
        check("decay_phase", dut.decay_cnt_q, 0);

        // Decay trail on channel 3
        led_in = 16'h0008;
        while (c < 58) begin
            step();
            check("hold_lvl3", lvl[3], 15);
        end
        led_in = '0;
        while (c < 120) begin
            step();
            check("decay_lvl3", lvl[3], lvl3_model(c));
            check("decay_out3", led_out[3], (exp_eff(lvl3_model(c - 1)) > ((c - 1) % 15)) ? 1 : 0);
        end
        check("decay_done", lvl[3], 0);

        // Load beats tick on channel 5
        led_in = 16'h0020;
        step();
        step();
        check("ld_lvl5", lvl[5], 15);
        led_in = '0;
        while (c < 155) step();
        check("pre_tick_lvl5", lvl[5], 7);
        check("pre_tick_cnt",  dut.decay_cnt_q, 3);
        led_in = 16'h0020;
        step();
        check("ld_vs_tick", lvl[5], 15);
        led_in = '0;

        // Rotating head, trail must fade with distance
        for (int k = 0; k < 20; k++) begin
            led_in = 16'(1 << (k % 16));
            repeat (6) step();
        end
        head = 3;
        check("rot_head", lvl[head], 15);
        check("rot_ch2_range", ((lvl[2] >= 13) && (lvl[2] <= 14)) ? 1 : 0, 1);
        check("rot_tail_dark", lvl[4], 0);
        for (int d = 1; d < 16; d++) begin
            check("rot_monotone",
                  (lvl[(head - d) & 15] <= lvl[(head - d + 1) & 15]) ? 1 : 0, 1);
        end

        // Single-cycle reset mid-run, input still active
        rst = 1'b1;
        step();
        any_lvl = 1'b0;
        for (int i = 0; i < N; i++) any_lvl |= (lvl[i] != '0);
        check("mid_rst_lvl",   any_lvl, 0);
        check("mid_rst_out",   led_out, 0);
        check("mid_rst_pwm",   dut.pwm_cnt_q, 0);
        check("mid_rst_decay", dut.decay_cnt_q, 0);
        rst    = 1'b0;
        led_in = '0;
        c      = 0;
        step();
        check("post_rst_out",  led_out, 0);
        check("post_rst_lvl3", lvl[3], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
